// File: rtl/dfr_seq_pkg.sv
// Shared definitions for the dfr_run_sequencer slice: sequencer state
// encoding and the default widths of the run and latency counters.
package dfr_seq_pkg;

  localparam int DFR_SEQ_CNT_W = 32;
  localparam int DFR_SEQ_LAT_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    FIN       = 2'd3
  } seq_state_e;

endpackage

// File: rtl/dfr_lat_stats.sv
// Per-inference latency measurement for dfr_run_sequencer.
// A cycle counter is loaded with 1 on the first start cycle of every
// inference and records its value on the done cycle, so the recorded
// latency covers the first start cycle through the done cycle inclusive.
module dfr_lat_stats
  import dfr_seq_pkg::*;
#(
  parameter int LAT_W = DFR_SEQ_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             count_en,
  input  logic             done,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat
);

  logic [LAT_W-1:0] lat_cnt;

  // Cycle counter for the inference in flight; saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (load) begin
      lat_cnt <= LAT_W'(1);
    end else if (count_en && (lat_cnt != '1)) begin
      lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  // Capture the finished inference's latency and fold it into min/max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lat <= '0;
      min_lat  <= '1;
      max_lat  <= '0;
    end else if (clear) begin
      last_lat <= '0;
      min_lat  <= '1;
      max_lat  <= '0;
    end else if (done) begin
      last_lat <= lat_cnt;
      if (lat_cnt < min_lat) begin
        min_lat <= lat_cnt;
      end
      if (lat_cnt > max_lat) begin
        max_lat <= lat_cnt;
      end
    end
  end

endmodule

// File: rtl/dfr_run_sequencer.sv
// Batch sequencer driving a dfr_inference core over ap_ctrl_hs.
// A cfg_start pulse launches cfg_num_runs back-to-back inferences; finish
// stays high once the batch completes until the next batch is accepted.
// Optional macro DFR_SEQ_LAT_STATS_EN compiles in the latency counter and
// last/min/max statistics; without it those outputs are tied to zero.
module dfr_run_sequencer
  import dfr_seq_pkg::*;
#(
  parameter int CNT_W = DFR_SEQ_CNT_W,
  parameter int LAT_W = DFR_SEQ_LAT_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_runs,
  output logic             core_ap_start,
  input  logic             core_ap_ready,
  input  logic             core_ap_done,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] runs_done,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat,
  output logic             proto_err
);

  seq_state_e       state;
  seq_state_e       state_next;
  logic             accept;
  logic             run_done;
  logic             proto_evt;
  logic             last_run;
  logic [CNT_W-1:0] num_runs_q;
  logic [CNT_W-1:0] runs_done_inc;

  assign runs_done_inc = runs_done + CNT_W'(1);
  assign last_run      = (runs_done_inc == num_runs_q);

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the accept / completion / violation strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    run_done   = 1'b0;
    proto_evt  = 1'b0;
    case (state)
      IDLE, FIN: begin
        if (core_ap_done) begin
          proto_evt = 1'b1;
        end
        if (cfg_start) begin
          accept     = 1'b1;
          state_next = (cfg_num_runs == '0) ? FIN : START;
        end
      end
      START: begin
        if (core_ap_done) begin
          run_done   = 1'b1;
          state_next = last_run ? FIN : START;
        end else if (core_ap_ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (core_ap_ready) begin
          proto_evt = 1'b1;
        end
        if (core_ap_done) begin
          run_done   = 1'b1;
          state_next = last_run ? FIN : START;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Batch bookkeeping: sampled run count and completed-run counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      num_runs_q <= '0;
      runs_done  <= '0;
    end else if (accept) begin
      num_runs_q <= cfg_num_runs;
      runs_done  <= '0;
    end else if (run_done) begin
      runs_done <= runs_done_inc;
    end
  end

  // Sticky violation flag; a violation seen in the accept cycle still sticks.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      proto_err <= 1'b0;
    end else if (proto_evt) begin
      proto_err <= 1'b1;
    end else if (accept) begin
      proto_err <= 1'b0;
    end
  end

  assign core_ap_start = (state == START);
  assign busy          = (state == START) || (state == WAIT_DONE);
  assign finish        = (state == FIN);

`ifdef DFR_SEQ_LAT_STATS_EN
  logic lat_load;

  // A new inference begins whenever START is entered, including START->START.
  assign lat_load = (state_next == START) && ((state != START) || run_done);

  dfr_lat_stats #(
    .LAT_W(LAT_W)
  ) u_lat_stats (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .clear    (accept),
    .load     (lat_load),
    .count_en (busy),
    .done     (run_done),
    .last_lat (last_lat),
    .min_lat  (min_lat),
    .max_lat  (max_lat)
  );
`else
  assign last_lat = '0;
  assign min_lat  = '0;
  assign max_lat  = '0;
`endif

endmodule

// File: tb/tb_dfr_run_sequencer.sv
// Self-checking bench for dfr_run_sequencer. The bench plays the inference
// core: for each run it picks a ready offset and a done offset from the
// first start cycle, and predicts the handshake, finish timing and latency
// statistics from those offsets. Latency expectations follow whether
// DFR_SEQ_LAT_STATS_EN is defined for the build.
module tb_dfr_run_sequencer;

  localparam int CNT_W = 32;
  localparam int LAT_W = 32;

`ifdef DFR_SEQ_LAT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [LAT_W-1:0] MIN_INIT = STATS ? {LAT_W{1'b1}} : {LAT_W{1'b0}};

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b1;
  logic             cfg_start = 1'b0;
  logic [CNT_W-1:0] cfg_num_runs = '0;
  logic             core_ap_start;
  logic             core_ap_ready = 1'b0;
  logic             core_ap_done = 1'b0;
  logic             busy;
  logic             finish;
  logic [CNT_W-1:0] runs_done;
  logic [LAT_W-1:0] last_lat;
  logic [LAT_W-1:0] min_lat;
  logic [LAT_W-1:0] max_lat;
  logic             proto_err;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int d_off[16];
  int r_off[16];

  dfr_run_sequencer #(
    .CNT_W(CNT_W),
    .LAT_W(LAT_W)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .cfg_start     (cfg_start),
    .cfg_num_runs  (cfg_num_runs),
    .core_ap_start (core_ap_start),
    .core_ap_ready (core_ap_ready),
    .core_ap_done  (core_ap_done),
    .busy          (busy),
    .finish        (finish),
    .runs_done     (runs_done),
    .last_lat      (last_lat),
    .min_lat       (min_lat),
    .max_lat       (max_lat),
    .proto_err     (proto_err)
  );

  // Free-running clock.
  always #5 ap_clk = ~ap_clk;

  // Safety net in case a scenario never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one batch of n inferences using d_off/r_off. Optionally pulses a
  // stray ready or cfg_start during run 0, or aborts with reset at a given
  // run/offset. Checks flags, run count and statistics every cycle.
  task automatic run_batch(input string tag, input int n, input int abort_run,
                           input int abort_off, input int bad_ready_off,
                           input int bad_start_off);
    int               run;
    int               off;
    logic             exp_perr;
    logic [3:0]       exp_flags;
    logic [LAT_W-1:0] e_last;
    logic [LAT_W-1:0] e_min;
    logic [LAT_W-1:0] e_max;
    logic [LAT_W-1:0] lat;
    run = 0;
    off = 0;
    exp_perr = 1'b0;
    e_last = '0;
    e_min = MIN_INIT;
    e_max = '0;
    @(negedge ap_clk);
    cfg_start = 1'b1;
    cfg_num_runs = CNT_W'(n);
    @(negedge ap_clk);
    cfg_start = 1'b0;
    while (run < n) begin
      exp_flags = {(off <= r_off[run]), 1'b1, 1'b0, exp_perr};
      check_cnt++;
      if ({core_ap_start, busy, finish, proto_err} !== exp_flags)
        $display("[TB] FAIL %s flags run%0d off%0d: got %b expected %b", tag, run, off,
                 {core_ap_start, busy, finish, proto_err}, exp_flags);
      else pass_cnt++;
      check_cnt++;
      if (runs_done !== CNT_W'(run))
        $display("[TB] FAIL %s runs_done run%0d off%0d: got %0d expected %0d", tag, run, off,
                 runs_done, run);
      else pass_cnt++;
      check_cnt++;
      if ({last_lat, min_lat, max_lat} !== {e_last, e_min, e_max})
        $display("[TB] FAIL %s stats run%0d off%0d: got %0h/%0h/%0h expected %0h/%0h/%0h",
                 tag, run, off, last_lat, min_lat, max_lat, e_last, e_min, e_max);
      else pass_cnt++;
      if (run == abort_run && off == abort_off) begin
        ap_rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({core_ap_start, busy, finish, proto_err} !== 4'b0000)
          $display("[TB] FAIL %s reset flags: got %b expected 0000", tag,
                   {core_ap_start, busy, finish, proto_err});
        else pass_cnt++;
        check_cnt++;
        if (runs_done !== '0)
          $display("[TB] FAIL %s reset runs_done: got %0d expected 0", tag, runs_done);
        else pass_cnt++;
        check_cnt++;
        if ({last_lat, min_lat, max_lat} !== {{LAT_W{1'b0}}, MIN_INIT, {LAT_W{1'b0}}})
          $display("[TB] FAIL %s reset stats: got %0h/%0h/%0h expected 0/%0h/0", tag,
                   last_lat, min_lat, max_lat, MIN_INIT);
        else pass_cnt++;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        return;
      end
      core_ap_ready = (off == r_off[run]) || (run == 0 && off == bad_ready_off);
      core_ap_done  = (off == d_off[run]);
      if (run == 0 && off == bad_start_off) begin
        cfg_start = 1'b1;
        cfg_num_runs = CNT_W'(n + 5);
      end
      if (run == 0 && off == bad_ready_off) exp_perr = 1'b1;
      if (off == d_off[run]) begin
        if (STATS) begin
          lat = LAT_W'(off + 1);
          e_last = lat;
          if (lat < e_min) e_min = lat;
          if (lat > e_max) e_max = lat;
        end
        run++;
        off = 0;
      end else begin
        off++;
      end
      @(negedge ap_clk);
      core_ap_ready = 1'b0;
      core_ap_done = 1'b0;
      cfg_start = 1'b0;
    end
    check_cnt++;
    if ({core_ap_start, busy, finish, proto_err} !== {3'b001, exp_perr})
      $display("[TB] FAIL %s end flags: got %b expected %b", tag,
               {core_ap_start, busy, finish, proto_err}, {3'b001, exp_perr});
    else pass_cnt++;
    check_cnt++;
    if (runs_done !== CNT_W'(n))
      $display("[TB] FAIL %s end runs_done: got %0d expected %0d", tag, runs_done, n);
    else pass_cnt++;
    check_cnt++;
    if ({last_lat, min_lat, max_lat} !== {e_last, e_min, e_max})
      $display("[TB] FAIL %s end stats: got %0h/%0h/%0h expected %0h/%0h/%0h", tag,
               last_lat, min_lat, max_lat, e_last, e_min, e_max);
    else pass_cnt++;
  endtask

  // Asynchronous reset forces every output to its reset value at once.
  task automatic test_reset();
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({core_ap_start, busy, finish, proto_err} !== 4'b0000)
      $display("[TB] FAIL reset flags: got %b expected 0000",
               {core_ap_start, busy, finish, proto_err});
    else pass_cnt++;
    check_cnt++;
    if (runs_done !== '0) $display("[TB] FAIL reset runs_done: got %0d expected 0", runs_done);
    else pass_cnt++;
    check_cnt++;
    if ({last_lat, min_lat, max_lat} !== {{LAT_W{1'b0}}, MIN_INIT, {LAT_W{1'b0}}})
      $display("[TB] FAIL reset stats: got %0h/%0h/%0h expected 0/%0h/0",
               last_lat, min_lat, max_lat, MIN_INIT);
    else pass_cnt++;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  // Three runs, ready with the first start cycle, done four cycles later.
  task automatic test_three_runs();
    for (int i = 0; i < 3; i++) begin
      r_off[i] = 0;
      d_off[i] = 4;
    end
    run_batch("three_runs", 3, -1, -1, -1, -1);
  endtask

  // Empty batch from FIN: finish next cycle, statistics cleared, no start.
  task automatic test_zero_runs();
    run_batch("zero_runs", 0, -1, -1, -1, -1);
    @(negedge ap_clk);
    check_cnt++;
    if ({core_ap_start, busy, finish} !== 3'b001)
      $display("[TB] FAIL zero_runs hold: got %b expected 001", {core_ap_start, busy, finish});
    else pass_cnt++;
  endtask

  // Latencies 3 then 7; the second run has ready and done in the same cycle.
  task automatic test_min_max();
    r_off[0] = 0;
    d_off[0] = 2;
    r_off[1] = 6;
    d_off[1] = 6;
    run_batch("min_max", 2, -1, -1, -1, -1);
  endtask

  // Stray done in IDLE is sticky until the next batch; a stray ready and a
  // cfg_start while waiting for done are flagged and ignored respectively.
  task automatic test_protocol();
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    core_ap_done = 1'b1;
    @(negedge ap_clk);
    core_ap_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if ({busy, finish, proto_err} !== 3'b001)
        $display("[TB] FAIL proto_idle cycle%0d: got %b expected 001", i,
                 {busy, finish, proto_err});
      else pass_cnt++;
      @(negedge ap_clk);
    end
    r_off[0] = 0;
    d_off[0] = 5;
    run_batch("proto_wait", 1, -1, -1, 2, 3);
  endtask

  // Reset during the second of four runs, then a clean single-run batch.
  task automatic test_reset_mid_batch();
    for (int i = 0; i < 4; i++) begin
      r_off[i] = 1;
      d_off[i] = 5;
    end
    run_batch("abort", 4, 1, 3, -1, -1);
    r_off[0] = 2;
    d_off[0] = 3;
    run_batch("after_abort", 1, -1, -1, -1, -1);
  endtask

  // Random batches launched straight from FIN with random core timing.
  task automatic test_back_to_back();
    int n;
    for (int b = 0; b < 8; b++) begin
      n = (b == 5) ? 0 : int'($urandom_range(5, 1));
      for (int i = 0; i < n; i++) begin
        d_off[i] = int'($urandom_range(7, 0));
        r_off[i] = int'($urandom_range(d_off[i], 0));
      end
      run_batch("random", n, -1, -1, -1, -1);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_three_runs();
    test_zero_runs();
    test_min_max();
    test_protocol();
    test_reset_mid_batch();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dfr_run_sequencer.md
DFR_RUN_SEQUENCER -- requirements
Module: dfr_run_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of run count and run counter.
REQ-002 SHALL have parameter LAT_W, default 32: width of latency counters and statistics.
REQ-003 SHALL have port ap_clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port ap_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port cfg_start, input, 1: one-cycle pulse that launches a batch.
REQ-006 SHALL have port cfg_num_runs, input, CNT_W: number of inferences, sampled on an accepted cfg_start.
REQ-007 SHALL have port core_ap_start, output, 1: ap_ctrl_hs start to dfr_inference.
REQ-008 SHALL have port core_ap_ready, input, 1: ap_ctrl_hs ready from dfr_inference.
REQ-009 SHALL have port core_ap_done, input, 1: ap_ctrl_hs done from dfr_inference.
REQ-010 SHALL have port busy, output, 1: high while a batch is in progress.
REQ-011 SHALL have port finish, output, 1: level, high once the batch completes; feeds the dataflow monitor's finish input.
REQ-012 SHALL have port runs_done, output, CNT_W: completed inferences in the current batch.
REQ-013 SHALL have ports last_lat, min_lat and max_lat, outputs, LAT_W each: per-inference latency statistics in cycles.
REQ-014 SHALL have port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT_DONE and FIN.
REQ-016 cfg_start SHALL be accepted only in IDLE or FIN and ignored otherwise; acceptance clears runs_done, finish and proto_err and resets statistics.
REQ-017 On acceptance with cfg_num_runs==0, next state SHALL be FIN, with finish high the following cycle and core_ap_start never asserted.
REQ-018 On acceptance with cfg_num_runs>0, next state SHALL be START; core_ap_start SHALL be high exactly while in START.
REQ-019 START SHALL move to WAIT_DONE on core_ap_ready=1 without core_ap_done=1.
REQ-020 core_ap_done SHALL be honoured in START or WAIT_DONE; a same-cycle ready+done SHALL count as one completed inference.
REQ-021 On done, runs_done SHALL increment; next state SHALL be FIN if the new runs_done equals the sampled count, else START with no idle gap.
REQ-022 Latency counter SHALL load 1 on entry to START and increment each cycle in START/WAIT_DONE, saturating at all-ones.
REQ-023 Recorded latency SHALL span the first start cycle through the done cycle inclusive; last_lat SHALL update on the done cycle's clock edge.
REQ-024 min_lat SHALL reset to all-ones and max_lat to 0; each SHALL update with registered compare on every done.
REQ-025 core_ap_done while in IDLE or FIN, or core_ap_ready while in WAIT_DONE, SHALL set proto_err; the event is otherwise ignored.
REQ-026 busy SHALL be high in START and WAIT_DONE; finish SHALL be high in FIN only.

Reset
REQ-027 ap_rst_n low SHALL immediately force IDLE, core_ap_start=0, busy=0, finish=0, runs_done=0, last_lat=0, max_lat=0, min_lat=all-ones, proto_err=0.
REQ-028 Reset mid-batch SHALL abandon the batch with no finish pulse; the first accepted cfg_start after release SHALL start cleanly.

Configuration
REQ-029 Macro DFR_SEQ_LAT_STATS_EN defined SHALL compile in latency counter and last/min/max registers per REQ-022..024.
REQ-030 Without DFR_SEQ_LAT_STATS_EN, last_lat, min_lat and max_lat SHALL be tied to 0, no latency logic SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package dfr_seq_pkg SHALL hold the FSM state enum and default CNT_W/LAT_W constants.
REQ-032 Sub-module dfr_lat_stats SHALL implement the latency counter and statistics, instantiated only under DFR_SEQ_LAT_STATS_EN.

Verification
REQ-033 num_runs=3 with ready at start+0 and done at start+4 -> 3 start windows back-to-back, last/min/max=5, runs_done=3, finish high.
REQ-034 num_runs=0 -> finish high 1 cycle after cfg_start, core_ap_start never high.
REQ-035 num_runs=2 with done latencies 3 then 7 -> min_lat=3, max_lat=7, last_lat=7.
REQ-036 Spurious core_ap_done in IDLE -> proto_err=1 and sticky until the next cfg_start; cfg_start during WAIT_DONE -> ignored.
REQ-037 ap_rst_n low during WAIT_DONE of run 2 of 4 -> all outputs at reset values immediately; a new batch of 1 completes normally.
REQ-038 Build without DFR_SEQ_LAT_STATS_EN and rerun REQ-033 -> identical handshake and finish timing, latency outputs 0.
